// File: rtl/seg7_pkg.sv
// Shared 7-segment types, code table and decoder FSM states.
// Used by the hex encoder and by seg7_frame_decoder / seg7_to_hex.
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] hexd_t;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam seg7_t SEG7_CODES [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam seg7_t SEG7_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex digit decoder.
// Ports: seg (active-low pattern) -> digit (0..F), known (code or blank).
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_t       seg,
    output hexd_t       digit,
    output logic        known
);

    // Blank and unrecognised patterns both yield digit 0;
    // only the known flag tells them apart.
    always_comb begin
        digit = '0;
        known = (seg == SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_CODES[i]) begin
                digit = 4'(i);
                known = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Assembles NUM_DIGITS 7-segment digits into one hex word with error mask.
// Ports: seg_in/seg_valid/seg_first/seg_ready in, value/bad_mask/frame_err/out_valid/out_ready/resync out.
module seg7_frame_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    input  logic                    seg_first,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   bad_mask,
    output logic                    frame_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    resync
);

    localparam int IW = $clog2(NUM_DIGITS) + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    state_t        state;
    logic [IW-1:0] idx;
    hexd_t         dig;
    logic          known;
    logic          take;

    seg7_to_hex u_dec (
        .seg   (seg_in),
        .digit (dig),
        .known (known)
    );

    // Handshake outputs are decoded straight from the state register.
    assign seg_ready = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign frame_err = |bad_mask;
    assign take      = seg_valid && seg_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            value    <= '0;
            bad_mask <= '0;
            resync   <= 1'b0;
        end else begin
            resync <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Stray non-first digits are dropped silently.
                    if (take && seg_first) begin
                        value       <= '0;
                        value[3:0]  <= dig;
                        bad_mask    <= '0;
                        bad_mask[0] <= !known;
                        idx         <= IW'(1);
                        state       <= (NUM_DIGITS == 1) ? HOLD : COLLECT;
                    end
                end
                COLLECT: begin
                    if (take && seg_first) begin
                        // Restart: old partial frame is thrown away.
                        value       <= '0;
                        value[3:0]  <= dig;
                        bad_mask    <= '0;
                        bad_mask[0] <= !known;
                        idx         <= IW'(1);
                        resync      <= 1'b1;
                    end else if (take) begin
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            if (idx == IW'(k)) begin
                                value[4*k +: 4] <= dig;
                                bad_mask[k]     <= !known;
                            end
                        end
                        idx <= idx + IW'(1);
                        if (idx == LAST) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed self-checking bench for seg7_frame_decoder (NUM_DIGITS=6).
// Drives digits #1 after rising edges and samples outputs there.
module tb_seg7_frame_decoder;

    localparam int N = 6;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [6:0]     seg_in;
    logic           seg_valid;
    logic           seg_first;
    logic           seg_ready;
    logic [4*N-1:0] value;
    logic [N-1:0]   bad_mask;
    logic           frame_err;
    logic           out_valid;
    logic           out_ready;
    logic           resync;

    int checks = 0;
    int errors = 0;
    int rs_cnt = 0;
    int rs0;

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [6:0] blank = 7'b1111111;
    logic [6:0] junk  = 7'b0101010;

    seg7_frame_decoder #(.NUM_DIGITS(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_first (seg_first),
        .seg_ready (seg_ready),
        .value     (value),
        .bad_mask  (bad_mask),
        .frame_err (frame_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resync    (resync)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resync === 1'b1) rs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [6:0] p, input logic first);
        seg_in    = p;
        seg_first = first;
        seg_valid = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_first = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        seg_in    = '1;
        seg_valid = 1'b0;
        seg_first = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_bad", 32'(bad_mask), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_ovalid", 32'(out_valid), 32'h0);
        check("rst_resync", 32'(resync), 32'h0);
        check("rst_ready", 32'(seg_ready), 32'h1);
        reset_n = 1'b1;

        // 1: plain frame 1..6, consumer always ready
        send(pat[1], 1'b1);
        for (int i = 2; i <= 6; i++) send(pat[i], 1'b0);
        check("t1_ovalid", 32'(out_valid), 32'h1);
        check("t1_value", 32'(value), 32'h654321);
        check("t1_err", 32'(frame_err), 32'h0);
        check("t1_ready", 32'(seg_ready), 32'h0);
        @(posedge clk);
        #1;
        check("t1_ovalid_drop", 32'(out_valid), 32'h0);
        check("t1_ready_back", 32'(seg_ready), 32'h1);

        // 2: bad pattern in slot 3
        out_ready = 1'b0;
        send(pat[0], 1'b1);
        send(pat[1], 1'b0);
        send(pat[2], 1'b0);
        send(junk, 1'b0);
        send(pat[15], 1'b0);
        send(pat[14], 1'b0);
        check("t2_value", 32'(value), 32'hEF0210);
        check("t2_bad", 32'(bad_mask), 32'h08);
        check("t2_err", 32'(frame_err), 32'h1);
        check("t2_ovalid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t2_idle", 32'(out_valid), 32'h0);
        check("t2_retain", 32'(value), 32'hEF0210);

        // 3: restart mid-frame
        rs0 = rs_cnt;
        send(pat[1], 1'b1);
        check("t3_clear_value", 32'(value), 32'h000001);
        check("t3_clear_bad", 32'(bad_mask), 32'h0);
        check("t3_no_resync", 32'(resync), 32'h0);
        send(pat[2], 1'b0);
        send(pat[3], 1'b0);
        send(pat[7], 1'b1);
        check("t3_resync", 32'(resync), 32'h1);
        check("t3_restart", 32'(value), 32'h000007);
        send(pat[8], 1'b0);
        check("t3_resync_end", 32'(resync), 32'h0);
        for (int i = 0; i < 4; i++) send(pat[8], 1'b0);
        check("t3_value", 32'(value), 32'h888887);
        check("t3_ovalid", 32'(out_valid), 32'h1);
        check("t3_rs_count", 32'(rs_cnt - rs0), 32'h1);

        // 4: backpressure in HOLD with input hammering
        seg_in    = pat[9];
        seg_first = 1'b1;
        seg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t4_ready", 32'(seg_ready), 32'h0);
            check("t4_stable", 32'(value), 32'h888887);
            check("t4_ovalid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_first = 1'b0;
        check("t4_release", 32'(out_valid), 32'h0);
        check("t4_not_taken", 32'(value), 32'h888887);
        check("t4_ready_back", 32'(seg_ready), 32'h1);

        // 5: all-blank frame, then stray digits in IDLE
        send(blank, 1'b1);
        for (int i = 0; i < 5; i++) send(blank, 1'b0);
        check("t5_value", 32'(value), 32'h0);
        check("t5_bad", 32'(bad_mask), 32'h0);
        check("t5_err", 32'(frame_err), 32'h0);
        check("t5_ovalid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(pat[5], 1'b0);
        check("t5_stray_ovalid", 32'(out_valid), 32'h0);
        check("t5_stray_value", 32'(value), 32'h0);
        check("t5_stray_ready", 32'(seg_ready), 32'h1);

        // 6: reset in the middle of a frame
        send(pat[3], 1'b1);
        send(pat[4], 1'b0);
        send(pat[5], 1'b0);
        send(pat[6], 1'b0);
        check("t6_partial", 32'(value), 32'h006543);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_value", 32'(value), 32'h0);
        check("t6_rst_bad", 32'(bad_mask), 32'h0);
        check("t6_rst_ovalid", 32'(out_valid), 32'h0);
        check("t6_rst_resync", 32'(resync), 32'h0);
        check("t6_rst_ready", 32'(seg_ready), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 10; i <= 15; i++) send(pat[i], i == 10);
        check("t6_value", 32'(value), 32'hFEDCBA);
        check("t6_ovalid", 32'(out_valid), 32'h1);
        check("t6_err", 32'(frame_err), 32'h0);
        check("t6_rs_total", 32'(rs_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
